iic_target_responder: RTL and testbench
=======================================

// Module: iic_target_responder
// PURPOSE
//  I2C target (slave) that answers the team's I2C read/write initiator. It oversamples SCL/SDA on clk,
//  detects START/repeated START/STOP, matches a 7-bit address, ACKs, and handles the bus transfer.
//  Write transfers load an 8-bit register pointer and then data bytes. Read transfers return data
//  from an external register file through a simple strobe interface. It sits between the bus pads
//  and a local register bank.
// PARAMETERS
//  SLAVE_ADDR   7'h50  7-bit target address compared against the first byte after START
//  SYNC_STAGES  2      flops in the scl_in/sda_in synchronizers (min 2)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  scl_in     in   1  bus SCL level (async)
//  sda_in     in   1  bus SDA level (async)
//  sda_oe     out  1  1 = pull SDA low (open-drain); 0 = release
//  reg_addr   out  8  register pointer presented to register bank
//  reg_wdata  out  8  write data, valid while reg_we=1
//  reg_we     out  1  one-clk write strobe
//  reg_re     out  1  one-clk read strobe; reg_rdata sampled the next clk
//  reg_rdata  in   8  read data from register bank
//  busy       out  1  1 from address match until STOP / START / NACK-end
// BEHAVIOUR
//  Reset and clocking
//  - Reset: sda_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0, state=IDLE.
//    rst is asynchronous, so sda_oe releases immediately, including mid-transfer.
//  - SCL high/low phases must be >= 3 clk each. SDA must be stable >= 1 clk around the SCL rise.
//    No clock stretching.
//  Line events (from synchronized SCL/SDA and a one-clk-delayed copy)
//  - scl_rise, scl_fall: edges on the synchronized SCL.
//  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
//  - START/STOP have priority over bit handling in every state.
//  - START -> ADDR with bit_cnt=7 (also acts as repeated START). STOP -> IDLE, sda_oe=0, busy=0.
//  - A STOP mid-byte discards the partial byte and issues no reg_we.
//  Byte framing
//  - Bits shift in MSB first on scl_rise.
//  - ACK: sda_oe=1 from the scl_fall after the 8th rise to the next scl_fall.
//  States
//  - IDLE: ignore everything except START.
//  - ADDR: after 8 bits, if byte[7:1]==SLAVE_ADDR then ACK, busy=1, rw=byte[0]; otherwise go to
//    IDLE with no ACK.
//  - rw=0: ADDR_ACK -> PTR. The PTR byte loads reg_addr, then ACK -> WDATA.
//  - WDATA: after the 8th rise, reg_wdata=byte and reg_we pulses 1 clk. Then ACK. reg_addr
//    increments on the scl_fall that ends the ACK (8'hFF wraps to 8'h00). Further bytes repeat
//    WDATA.
//  - rw=1: reg_re pulses on the scl_fall that starts the address ACK. reg_rdata is latched into the
//    TX shift register 1 clk later.
//  - RDATA: on each scl_fall, drive sda_oe=~tx[bit]. After the 8th bit, release SDA on scl_fall.
//    Sample master ACK on scl_rise: SDA low means increment reg_addr, pulse reg_re, latch, and
//    repeat RDATA. SDA high (NACK) goes to WAIT_STOP with sda_oe=0.
//  - WAIT_STOP: drive nothing and wait for STOP or START.
//  - reg_addr persists across transfers, so write-pointer + repeated START + read forms a
//    random read.
//  - reg_we and reg_re never assert in the same clk.
// STRUCTURE
//  - Package iic_pkg: state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA,
//    RDATA_ACK, WAIT_STOP), default SYNC_STAGES, and the R/W bit constants.
//  - Sub-module iic_line_sync: synchronizers plus the scl_rise/scl_fall/start/stop pulse
//    generator.
//  - The FSM, shift registers and pointer live in the top module.
// TESTING
//  1. Single write: START, 0xA0, 0x10, 0x3C, STOP -> ACK on all 3 bytes; one reg_we with
//     reg_addr=0x10, reg_wdata=0x3C.
//  2. Burst write wrap: pointer 0xFF, data 0x11 then 0x22 -> reg_we at 0xFF=0x11 and 0x00=0x22.
//  3. Random read: write pointer 0x20, repeated START, 0xA1, reg_rdata=0x5A, master NACK, STOP ->
//     SDA bits 0,1,0,1,1,0,1,0; reg_re once; sda_oe=0 after the NACK.
//  4. Sequential read: 0xA1, master ACKs 2 bytes then NACKs -> reg_re 3 times, reg_addr
//     0x20..0x22.
//  5. Address mismatch: 0xA2 -> no ACK, busy=0, no strobes until the next START; a following 0xA0
//     is ACKed.
//  6. Aborts: STOP after 4 bits of WDATA -> no reg_we. rst during RDATA with sda_oe=1 -> sda_oe=0
//     immediately and state=IDLE.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C target responder.
// State encoding, synchronizer depth default and the R/W bit meaning.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } iic_state_t;

    localparam int   DEFAULT_SYNC_STAGES = 2;
    localparam logic RW_WRITE            = 1'b0;
    localparam logic RW_READ             = 1'b1;

endpackage

// File: rtl/iic_line_sync.sv
// Synchronizes SCL/SDA into clk and derives one-clk line event pulses:
// SCL rise/fall, START (SDA falls, SCL high) and STOP (SDA rises, SCL high).
module iic_line_sync
    import iic_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high on both lines, so reset to 1 to avoid phantom events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/iic_target_responder.sv
// I2C target: address match, register-pointer write, burst write and burst read
// against an external register bank through one-clk reg_we/reg_re strobes.
module iic_target_responder
    import iic_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    iic_state_t state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       byte_full, byte_full_nxt;
    logic       rw, rw_nxt;
    logic       latch_pend, latch_pend_nxt;
    logic       sda_oe_nxt;
    logic [7:0] reg_addr_nxt;
    logic [7:0] reg_wdata_nxt;
    logic       reg_we_nxt;
    logic       reg_re_nxt;
    logic       busy_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] tx, tx_nxt;
    logic [7:0] rx_byte;

    iic_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign rx_byte = {shift[6:0], sda_s};

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        byte_full_nxt  = byte_full;
        rw_nxt         = rw;
        sda_oe_nxt     = sda_oe;
        reg_addr_nxt   = reg_addr;
        reg_wdata_nxt  = reg_wdata;
        reg_we_nxt     = 1'b0;
        reg_re_nxt     = 1'b0;
        busy_nxt       = busy;
        shift_nxt      = shift;
        // Bank returns read data the clk after reg_re; capture it one clk later still.
        latch_pend_nxt = reg_re;
        tx_nxt         = latch_pend ? reg_rdata : tx;

        if (stop_det) begin
            state_nxt     = IDLE;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            byte_full_nxt = 1'b0;
        end else if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd7;
            byte_full_nxt = 1'b0;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && !byte_full) begin
                        shift_nxt = rx_byte;
                        if (bit_cnt == 3'd0) begin
                            byte_full_nxt = 1'b1;
                            if (state == PTR) begin
                                reg_addr_nxt = rx_byte;
                            end else if (state == WDATA) begin
                                reg_wdata_nxt = rx_byte;
                                reg_we_nxt    = 1'b1;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd7;
                        if (state == ADDR) begin
                            if (shift[7:1] == SLAVE_ADDR) begin
                                state_nxt  = ADDR_ACK;
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                                rw_nxt     = shift[0];
                                reg_re_nxt = (shift[0] == RW_READ);
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else if (state == PTR) begin
                            state_nxt  = PTR_ACK;
                            sda_oe_nxt = 1'b1;
                        end else begin
                            state_nxt  = WDATA_ACK;
                            sda_oe_nxt = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 3'd7;
                        if (rw == RW_WRITE) begin
                            state_nxt  = PTR;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            state_nxt  = RDATA;
                            sda_oe_nxt = ~tx[7];
                        end
                    end
                end
                PTR_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = WDATA;
                        sda_oe_nxt = 1'b0;
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt    = WDATA;
                        sda_oe_nxt   = 1'b0;
                        reg_addr_nxt = reg_addr + 8'd1;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            state_nxt  = RDATA_ACK;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            bit_cnt_nxt = bit_cnt - 3'd1;
                            sda_oe_nxt  = ~tx[bit_cnt - 3'd1];
                        end
                    end
                end
                RDATA_ACK: begin
                    // byte_full marks "master ACKed, next byte fetch under way".
                    if (scl_rise && !byte_full) begin
                        if (!sda_s) begin
                            reg_addr_nxt  = reg_addr + 8'd1;
                            reg_re_nxt    = 1'b1;
                            byte_full_nxt = 1'b1;
                        end else begin
                            state_nxt  = WAIT_STOP;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                        end
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        state_nxt     = RDATA;
                        bit_cnt_nxt   = 3'd7;
                        sda_oe_nxt    = ~tx[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            byte_full  <= 1'b0;
            rw         <= 1'b0;
            latch_pend <= 1'b0;
            sda_oe     <= 1'b0;
            reg_addr   <= 8'h00;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_full  <= byte_full_nxt;
            rw         <= rw_nxt;
            latch_pend <= latch_pend_nxt;
            sda_oe     <= sda_oe_nxt;
            reg_addr   <= reg_addr_nxt;
            reg_wdata  <= reg_wdata_nxt;
            reg_we     <= reg_we_nxt;
            reg_re     <= reg_re_nxt;
            busy       <= busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
        tx    <= tx_nxt;
    end

endmodule

// File: tb/tb_iic_target_responder.sv
// Bench for iic_target_responder: bit-banged I2C master, register bank model
// and strobe scoreboard for reg_we/reg_re.
module tb_iic_target_responder;
    import iic_pkg::*;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    int checks = 0;
    int errors = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    iic_target_responder #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Strobe scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we && reg_re) begin
                errors++;
                $display("FAIL strobe_overlap we=%b re=%b", reg_we, reg_re);
            end
            if (reg_we) begin
                checks++;
                if (we_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_we addr=%h data=%h", reg_addr, reg_wdata);
                end else begin
                    logic [15:0] exp_w;
                    exp_w = we_q.pop_front();
                    if ({reg_addr, reg_wdata} !== exp_w) begin
                        errors++;
                        $display("FAIL we_value got=%h/%h exp=%h/%h", reg_addr, reg_wdata,
                                 exp_w[15:8], exp_w[7:0]);
                    end
                end
            end
            if (reg_re) begin
                checks++;
                if (re_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_re addr=%h", reg_addr);
                end else begin
                    logic [7:0] exp_r;
                    exp_r = re_q.pop_front();
                    if (reg_addr !== exp_r) begin
                        errors++;
                        $display("FAIL re_addr got=%h exp=%h", reg_addr, exp_r);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b0; tick(2);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(H);
        scl_m = 1'b1; tick(H);
        scl_m = 1'b0; tick(2);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H / 2);
        b = sda_bus;  tick(H / 2);
        scl_m = 1'b0; tick(2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks += 6;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
        if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re got=%b exp=0", reg_re); end
        if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
        if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got=%h exp=00", reg_wdata); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single_write();
        logic a;
        bus_start();
        write_byte(8'hA0, a);
        checks += 2;
        if (a !== 1'b0) begin errors++; $display("FAIL sw_addr_ack got=%b exp=0", a); end
        if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy got=%b exp=1", busy); end
        write_byte(8'h10, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL sw_ptr_ack got=%b exp=0", a); end
        we_q.push_back({8'h10, 8'h3C});
        write_byte(8'h3C, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL sw_data_ack got=%b exp=0", a); end
        bus_stop();
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_after_stop got=%b exp=0", busy); end
        if (reg_addr !== 8'h11) begin errors++; $display("FAIL sw_ptr_incr got=%h exp=11", reg_addr); end
        if (we_q.size() != 0) begin errors++; $display("FAIL sw_we_missing left=%0d exp=0", we_q.size()); end
    endtask

    task automatic test_burst_wrap();
        logic a;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'hFF, a);
        we_q.push_back({8'hFF, 8'h11});
        write_byte(8'h11, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL bw_ack1 got=%b exp=0", a); end
        we_q.push_back({8'h00, 8'h22});
        write_byte(8'h22, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL bw_ack2 got=%b exp=0", a); end
        bus_stop();
        checks += 2;
        if (reg_addr !== 8'h01) begin errors++; $display("FAIL bw_ptr got=%h exp=01", reg_addr); end
        if (we_q.size() != 0) begin errors++; $display("FAIL bw_we_missing left=%0d exp=0", we_q.size()); end
    endtask

    task automatic test_random_read();
        logic a;
        logic [7:0] d;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h20, a);
        bus_start();
        re_q.push_back(8'h20);
        write_byte(8'hA1, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL rr_addr_ack got=%b exp=0", a); end
        read_byte(d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL rr_data got=%h exp=5a", d); end
        write_bit(1'b1);
        tick(2);
        checks += 2;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL rr_release got=%b exp=0", sda_oe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_nack got=%b exp=0", busy); end
        bus_stop();
        checks += 2;
        if (reg_addr !== 8'h20) begin errors++; $display("FAIL rr_ptr got=%h exp=20", reg_addr); end
        if (re_q.size() != 0) begin errors++; $display("FAIL rr_re_missing left=%0d exp=0", re_q.size()); end
    endtask

    task automatic test_seq_read();
        logic a;
        logic [7:0] d;
        bus_start();
        re_q.push_back(8'h20);
        write_byte(8'hA1, a);
        read_byte(d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL sr_byte0 got=%h exp=5a", d); end
        re_q.push_back(8'h21);
        write_bit(1'b0);
        read_byte(d);
        checks++;
        if (d !== 8'hC3) begin errors++; $display("FAIL sr_byte1 got=%h exp=c3", d); end
        re_q.push_back(8'h22);
        write_bit(1'b0);
        read_byte(d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL sr_byte2 got=%h exp=81", d); end
        write_bit(1'b1);
        bus_stop();
        checks += 2;
        if (reg_addr !== 8'h22) begin errors++; $display("FAIL sr_ptr got=%h exp=22", reg_addr); end
        if (re_q.size() != 0) begin errors++; $display("FAIL sr_re_missing left=%0d exp=0", re_q.size()); end
    endtask

    task automatic test_mismatch();
        logic a;
        bus_start();
        write_byte(8'hA2, a);
        checks += 2;
        if (a !== 1'b1) begin errors++; $display("FAIL mm_nack got=%b exp=1", a); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got=%b exp=0", busy); end
        write_byte(8'h00, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL mm_ignored got=%b exp=1", a); end
        bus_start();
        write_byte(8'hA0, a);
        checks += 2;
        if (a !== 1'b0) begin errors++; $display("FAIL mm_next_ack got=%b exp=0", a); end
        if (busy !== 1'b1) begin errors++; $display("FAIL mm_next_busy got=%b exp=1", busy); end
        bus_stop();
    endtask

    task automatic test_abort_stop();
        logic a;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h30, a);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        bus_stop();
        tick(4);
        checks += 2;
        if (reg_addr !== 8'h30) begin errors++; $display("FAIL as_ptr got=%h exp=30", reg_addr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL as_busy got=%b exp=0", busy); end
    endtask

    task automatic test_abort_reset();
        logic a;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h30, a);
        bus_start();
        re_q.push_back(8'h30);
        write_byte(8'hA1, a);
        tick(4);
        checks++;
        if (sda_oe !== 1'b1) begin errors++; $display("FAIL ar_driving got=%b exp=1", sda_oe); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (sda_oe !== 1'b0) begin errors++; $display("FAIL ar_async_release got=%b exp=0", sda_oe); end
        if (dut.state !== IDLE) begin errors++; $display("FAIL ar_state got=%0d exp=%0d", dut.state, IDLE); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", busy); end
        if (reg_addr !== 8'h00) begin errors++; $display("FAIL ar_ptr got=%h exp=00", reg_addr); end
        tick(2);
        rst = 1'b0;
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        checks++;
        if (re_q.size() != 0) begin errors++; $display("FAIL ar_re_missing left=%0d exp=0", re_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        mem[8'h22] = 8'h81;
        mem[8'h30] = 8'h00;
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_random_read();
        test_seq_read();
        test_mismatch();
        test_abort_stop();
        test_abort_reset();
        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
